d_ff_neg: RTL and testbench

D_FF_NEG -- requirements
Module: d_ff_neg

---
 rtl/d_ff_neg.sv | 27 ++
 tb/tb_d_ff_neg.sv | 115 +++++++++++
 2 files changed

// File: rtl/d_ff_neg.sv
// Falling-edge D flip-flop with synchronous active-low reset and complementary output.
// QN is the inverse of the same storage element, so Q and QN can never disagree.
module d_ff_neg #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] D,
    input  logic             CLK,
    output logic [WIDTH-1:0] Q,
    input  logic             RST_N,
    output logic [WIDTH-1:0] QN
);

    logic [WIDTH-1:0] q_r;

    // Capture D on the falling edge; a low RST_N sampled at the same edge wins over D.
    always_ff @(negedge CLK) begin
        if (!RST_N) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= D;
        end
    end

    assign Q  = q_r;
    assign QN = ~q_r;

endmodule

// File: tb/tb_d_ff_neg.sv
// Directed bench for d_ff_neg: 1-bit and 8-bit instances share clock and reset.
module tb_d_ff_neg;

    logic       clk;
    logic       rst_n;
    logic       d1;
    logic       q1;
    logic       qn1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    int checks_total;
    int checks_passed;
    int checks_failed;

    d_ff_neg #(.WIDTH(1)) dut1 (
        .D    (d1),
        .CLK  (clk),
        .Q    (q1),
        .RST_N(rst_n),
        .QN   (qn1)
    );

    d_ff_neg #(.WIDTH(8)) dut8 (
        .D    (d8),
        .CLK  (clk),
        .Q    (q8),
        .RST_N(rst_n),
        .QN   (qn8)
    );

    // Period 10 ns, starting low: rising edges at 5, 15, ... falling edges at 10, 20, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            checks_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        checks_failed = 0;
        rst_n = 1'b1;
        d1    = 1'b0;
        d8    = 8'h00;

        // Scenario 1: basic capture, D changes 2 ns after each falling edge
        #12 d1 = 1'b1;                          // t=12
        #3  check("s1_q_10", {63'd0, q1}, 64'd0);     // t=15
            check("s1_qn_10", {63'd0, qn1}, 64'd1);
        #7  d1 = 1'b0;                          // t=22
        #3  check("s1_q_20", {63'd0, q1}, 64'd1);     // t=25
            check("s1_qn_20", {63'd0, qn1}, 64'd0);
        #7  d1 = 1'b1;                          // t=32
        #3  check("s1_q_30", {63'd0, q1}, 64'd0);     // t=35
        #7  d1 = 1'b0;                          // t=42
        #3  check("s1_q_40", {63'd0, q1}, 64'd1);     // t=45
            check("s1_qn_40", {63'd0, qn1}, 64'd0);
        #10 check("s1_q_50", {63'd0, q1}, 64'd0);     // t=55

        // Scenario 2: D pulses high across the rising edge at 65 only
        #9  d1 = 1'b1;                          // t=64
        #2  check("s2_q_rise", {63'd0, q1}, 64'd0);   // t=66
        #2  d1 = 1'b0;                          // t=68
        #4  check("s2_q_fall", {63'd0, q1}, 64'd0);   // t=72
            check("s2_qn_fall", {63'd0, qn1}, 64'd1);

        // Scenario 3: load 1, then assert reset mid-cycle
            d1 = 1'b1;                          // t=72
            d8 = 8'h77;
        #10 check("s3_q_loaded", {63'd0, q1}, 64'd1); // t=82
            check("s3_q8_loaded", {56'd0, q8}, 64'h77);
        #1  rst_n = 1'b0;                       // t=83
        #4  check("s3_q_hold", {63'd0, q1}, 64'd1);   // t=87
            check("s3_q8_hold", {56'd0, q8}, 64'h77);
        #5  check("s3_q_reset", {63'd0, q1}, 64'd0);  // t=92
            check("s3_qn_reset", {63'd0, qn1}, 64'd1);
            check("s3_q8_reset", {56'd0, q8}, 64'h00);
            check("s3_qn8_reset", {56'd0, qn8}, 64'hFF);

        // Scenario 4: reset wins over D=1, release between edges, then capture
        #10 check("s4_q_prio", {63'd0, q1}, 64'd0);   // t=102
            check("s4_q8_prio", {56'd0, q8}, 64'h00);
        #1  rst_n = 1'b1;                       // t=103
        #4  check("s4_q_release", {63'd0, q1}, 64'd0); // t=107
        #5  check("s4_q_after", {63'd0, q1}, 64'd1);  // t=112
            check("s4_qn_after", {63'd0, qn1}, 64'd0);

        // Scenario 5: multi-bit capture on consecutive falling edges
            d8 = 8'hA5;                         // t=112
        #10 check("s5_q8_a5", {56'd0, q8}, 64'hA5);   // t=122
            check("s5_qn8_a5", {56'd0, qn8}, 64'h5A);
            d8 = 8'h3C;
        #10 check("s5_q8_3c", {56'd0, q8}, 64'h3C);   // t=132
            check("s5_qn8_3c", {56'd0, qn8}, 64'hC3);
        #1  d8 = 8'hFF;                         // t=133
        #2  check("s5_q8_hold", {56'd0, q8}, 64'h3C); // t=135
        #2  d8 = 8'h3C;                         // t=137
        #5  check("s5_q8_stable", {56'd0, q8}, 64'h3C); // t=142

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
